// File: rtl/hazard_pkg.sv
// Shared types and width helpers for the hazard controller: the tracked tag-entry
// layout, select/latency width derivations and the register-file select code.
package hazard_pkg;

  // Entry fields are sized for the widest supported configuration; narrower
  // register addresses and latency codes are zero-extended on load.
  localparam int ADDR_W_MAX  = 8;
  localparam int LAT_W_MAX   = 4;
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_W_MAX-1:0] dest;
    logic [LAT_W_MAX-1:0]  lat;
  } entry_t;

  function automatic int lat_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Per-read-port youngest-producer search: reports a forward select or a
// hazard when the matching producer has not yet reached its forwardable stage.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int ADDR_W = 5
) (
  input  entry_t [DEPTH-1:0]       pipe,
  input  logic [ADDR_W-1:0]        src,
  input  logic                     used,
  output logic                     hazard,
  output logic [sel_w(DEPTH)-1:0]  sel
);

  localparam int SEL_W = sel_w(DEPTH);

  logic                  hit;
  logic [SEL_W-1:0]      hit_stage;
  logic [LAT_W_MAX-1:0]  hit_lat;
  logic [ADDR_W_MAX-1:0] src_ext;

  // Scan oldest to youngest so the youngest match overwrites (write-after-write).
  always_comb begin
    src_ext   = ADDR_W_MAX'(src);
    hit       = 1'b0;
    hit_stage = '0;
    hit_lat   = '0;
    for (int s = DEPTH - 1; s >= 0; s--) begin
      if (pipe[s].valid && (pipe[s].dest != '0) && (pipe[s].dest == src_ext)) begin
        hit       = 1'b1;
        hit_stage = SEL_W'(s);
        hit_lat   = pipe[s].lat;
      end
    end
  end

  always_comb begin
    hazard = 1'b0;
    sel    = SEL_W'(FWD_REGFILE);
    if (used && (src != '0) && hit) begin
      if (int'(hit_stage) >= int'(hit_lat)) begin
        sel = hit_stage + SEL_W'(1);
      end else begin
        hazard = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tag shift register, per-port forward select, stall.
// Optional perf counters (stall/flush cycles) exist only with HAZARD_CTRL_PERF_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 3,
  parameter int NRD    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stop,
  input  logic                          flush,
  input  logic                          iss_valid,
  input  logic [ADDR_W-1:0]             iss_dest,
  input  logic [lat_w(DEPTH)-1:0]       iss_lat,
  input  logic [NRD*ADDR_W-1:0]         iss_src,
  input  logic [NRD-1:0]                iss_src_used,
  output logic                          stall,
  output logic [NRD*sel_w(DEPTH)-1:0]   fwd_sel,
  output logic [DEPTH-1:0]              occ
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0]                   perf_stall_cnt,
  output logic [31:0]                   perf_flush_cnt
`endif
);

  localparam int LAT_W = lat_w(DEPTH);
  localparam int SEL_W = sel_w(DEPTH);

  if (DATA_W < 1 || ADDR_W < 1 || ADDR_W > ADDR_W_MAX) begin : g_bad_width
    $error("hazard_ctrl: DATA_W/ADDR_W out of supported range");
  end
  if (LAT_W > LAT_W_MAX || DEPTH < 1 || NRD < 1) begin : g_bad_depth
    $error("hazard_ctrl: DEPTH/NRD out of supported range");
  end

  entry_t [DEPTH-1:0] pipe;
  logic   [NRD-1:0]   port_hazard;
  logic               load_vld;

  for (genvar k = 0; k < NRD; k++) begin : g_port
    hazard_match #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_match (
      .pipe   (pipe),
      .src    (iss_src[k*ADDR_W +: ADDR_W]),
      .used   (iss_src_used[k]),
      .hazard (port_hazard[k]),
      .sel    (fwd_sel[k*SEL_W +: SEL_W])
    );
  end

  assign stall    = iss_valid & (|port_hazard);
  // A stalled or flushed decode slot enters the pipe as a bubble.
  assign load_vld = iss_valid & ~stall & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe <= '0;
    end else if (!stop) begin
      if (load_vld) begin
        pipe[0].valid <= 1'b1;
        pipe[0].dest  <= ADDR_W_MAX'(iss_dest);
        pipe[0].lat   <= LAT_W_MAX'(iss_lat);
      end else begin
        pipe[0] <= '0;
      end
      for (int s = 1; s < DEPTH; s++) begin
        pipe[s] <= pipe[s-1];
      end
    end
  end

  always_comb begin
    occ = '0;
    for (int s = 0; s < DEPTH; s++) begin
      occ[s] = pipe[s].valid;
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall && !stop && (perf_stall_cnt != '1)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (flush && !stop && (perf_flush_cnt != '1)) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       stop = 1'b0;
  logic       flush = 1'b0;
  logic       iss_valid = 1'b0;
  logic [4:0] iss_dest = '0;
  logic [1:0] iss_lat = '0;
  logic [9:0] iss_src = '0;
  logic [1:0] iss_src_used = '0;
  logic       stall;
  logic [3:0] fwd_sel;
  logic [2:0] occ;
`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       stop, flush, v;
    logic [4:0] dest;
    logic [1:0] lat;
    logic [4:0] s0, s1;
    logic [1:0] used;
    logic       e_stall;
    logic [1:0] e_f0, e_f1;
    logic [2:0] e_occ;
  } vec_t;

  typedef struct packed {
    logic       stall;
    logic [1:0] f0;
    logic [1:0] f1;
    logic [2:0] occ;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[25];

  always #5 clk = ~clk;

  hazard_ctrl #(
    .DATA_W (32),
    .ADDR_W (5),
    .DEPTH  (3),
    .NRD    (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stop         (stop),
    .flush        (flush),
    .iss_valid    (iss_valid),
    .iss_dest     (iss_dest),
    .iss_lat      (iss_lat),
    .iss_src      (iss_src),
    .iss_src_used (iss_src_used),
    .stall        (stall),
    .fwd_sel      (fwd_sel),
    .occ          (occ)
`ifdef HAZARD_CTRL_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  function automatic vec_t mk(input int st, input int fl, input int vv, input int d,
                              input int l, input int a, input int b, input int u,
                              input int es, input int f0, input int f1, input int o);
    vec_t r;
    r.stop = 1'(st);  r.flush = 1'(fl);  r.v = 1'(vv);
    r.dest = 5'(d);   r.lat = 2'(l);     r.s0 = 5'(a);  r.s1 = 5'(b);
    r.used = 2'(u);   r.e_stall = 1'(es);
    r.e_f0 = 2'(f0);  r.e_f1 = 2'(f1);   r.e_occ = 3'(o);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    stop         = v.stop;
    flush        = v.flush;
    iss_valid    = v.v;
    iss_dest     = v.dest;
    iss_lat      = v.lat;
    iss_src      = {v.s1, v.s0};
    iss_src_used = v.used;
  endtask

  task automatic step(input vec_t v, input string tag);
    exp_t e;
    drive(v);
    sb.push_back(exp_t'{v.e_stall, v.e_f0, v.e_f1, v.e_occ});
    #2;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, ".stall"}, 32'(stall), 32'(e.stall));
      check({tag, ".fwd0"}, 32'(fwd_sel[1:0]), 32'(e.f0));
      check({tag, ".fwd1"}, 32'(fwd_sel[3:2]), 32'(e.f1));
      check({tag, ".occ"}, 32'(occ), 32'(e.occ));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    stop = 1'b0; flush = 1'b0; iss_valid = 1'b0; iss_src_used = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // stop flush v dest lat s0 s1 used | stall f0 f1 occ
    tbl[0]  = mk(0,0,1, 8,0, 0,0,0, 0,0,0,3'b000);
    tbl[1]  = mk(0,0,1, 0,0, 8,0,1, 0,1,0,3'b001);
    tbl[2]  = mk(0,0,1, 0,0, 8,8,3, 0,2,2,3'b011);
    tbl[3]  = mk(0,0,0, 0,0, 8,8,3, 0,3,3,3'b111);
    tbl[4]  = mk(0,0,0, 0,0, 0,0,0, 0,0,0,3'b110);
    tbl[5]  = mk(0,0,0, 0,0, 0,0,0, 0,0,0,3'b100);
    tbl[6]  = mk(0,0,1, 8,1, 0,0,0, 0,0,0,3'b000);
    tbl[7]  = mk(0,0,1, 5,0, 0,8,2, 1,0,0,3'b001);
    tbl[8]  = mk(0,0,1, 5,0, 0,8,2, 0,0,2,3'b010);
    tbl[9]  = mk(0,0,1, 9,0, 5,8,3, 0,1,3,3'b101);
    tbl[10] = mk(0,0,1, 7,0, 0,0,0, 0,0,0,3'b011);
    tbl[11] = mk(0,0,1, 9,0, 0,0,0, 0,0,0,3'b111);
    tbl[12] = mk(0,0,1, 0,0, 9,7,3, 0,1,2,3'b111);
    tbl[13] = mk(0,1,1, 3,1, 0,0,0, 0,0,0,3'b111);
    tbl[14] = mk(0,0,1, 3,1, 0,0,0, 0,0,0,3'b110);
    tbl[15] = mk(0,1,1, 4,0, 3,0,1, 1,0,0,3'b101);
    tbl[16] = mk(0,0,0, 0,0, 3,0,1, 0,2,0,3'b010);
    tbl[17] = mk(0,0,1, 0,0, 3,0,0, 0,0,0,3'b100);
    tbl[18] = mk(0,0,1, 0,0, 0,0,1, 0,0,0,3'b001);
    tbl[19] = mk(0,1,1, 6,0, 0,0,0, 0,0,0,3'b011);
    tbl[20] = mk(0,0,0, 0,0, 0,0,0, 0,0,0,3'b110);
    tbl[21] = mk(0,0,1,12,2, 0,0,0, 0,0,0,3'b100);
    tbl[22] = mk(0,0,1, 1,0,12,0,1, 1,0,0,3'b001);
    tbl[23] = mk(0,0,1, 1,0,12,0,1, 1,0,0,3'b010);
    tbl[24] = mk(0,0,1, 1,0,12,0,1, 0,3,0,3'b100);

    // Reset state with hazard-looking inputs applied.
    iss_valid = 1'b1; iss_dest = 5'd8; iss_src = {5'd8, 5'd8}; iss_src_used = 2'b11;
    @(negedge clk);
    @(negedge clk);
    check("rst.occ", 32'(occ), 32'd0);
    check("rst.stall", 32'(stall), 32'd0);
    check("rst.fwd", 32'(fwd_sel), 32'd0);
    iss_valid = 1'b0; iss_src_used = '0;
    rst = 1'b1;

    for (int i = 0; i < 25; i++) begin
      step(tbl[i], $sformatf("v%0d", i));
    end

    // Freeze with a forwardable producer in stage 0, then release.
    do_reset();
    step(mk(0,0,1,8,0,0,0,0, 0,0,0,3'b000), "stop.load");
    for (int i = 0; i < 4; i++) begin
      step(mk(1,0,1,3,0,8,0,1, 0,1,0,3'b001), $sformatf("stop.hold%0d", i));
    end
    step(mk(0,0,0,0,0,8,0,1, 0,1,0,3'b001), "stop.rel0");
    step(mk(0,0,0,0,0,8,0,1, 0,2,0,3'b010), "stop.rel1");
    step(mk(0,0,0,0,0,8,0,1, 0,3,0,3'b100), "stop.rel2");
    step(mk(0,0,0,0,0,8,0,1, 0,0,0,3'b000), "stop.rel3");

    // Freeze during a load-use stall keeps the stall asserted.
    do_reset();
    step(mk(0,0,1,8,1,0,0,0, 0,0,0,3'b000), "stst.load");
    for (int i = 0; i < 3; i++) begin
      step(mk(1,0,1,5,0,8,0,1, 1,0,0,3'b001), $sformatf("stst.hold%0d", i));
    end
    step(mk(0,0,1,5,0,8,0,1, 1,0,0,3'b001), "stst.bubble");
    step(mk(0,0,1,5,0,8,0,1, 0,2,0,3'b010), "stst.fwd");

    // Asynchronous reset in the middle of a stall.
    do_reset();
    step(mk(0,0,1,8,1,0,0,0, 0,0,0,3'b000), "rms.load");
    step(mk(0,0,1,5,0,8,0,1, 1,0,0,3'b001), "rms.stall");
    #1 rst = 1'b0;
    #1;
    check("rms.async.occ", 32'(occ), 32'd0);
    check("rms.async.stall", 32'(stall), 32'd0);
    check("rms.async.fwd", 32'(fwd_sel), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #2;
    check("rms.rel.occ", 32'(occ), 32'd0);
    check("rms.rel.stall", 32'(stall), 32'd0);
    step(mk(0,0,1,5,0,8,0,1, 0,0,0,3'b001), "rms.after");

`ifdef HAZARD_CTRL_PERF_EN
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(mk(0,0,1,8,1,0,0,0, 0,0,0,0));
      drive(mk(0,0,1,0,0,8,0,1, 0,0,0,0));
      drive(mk(0,0,1,0,0,8,0,1, 0,0,0,0));
    end
    drive(mk(0,1,1,3,0,0,0,0, 0,0,0,0));
    drive(mk(0,1,1,3,0,0,0,0, 0,0,0,0));
    drive(mk(0,0,0,0,0,0,0,0, 0,0,0,0));
    #2;
    check("perf.stall", perf_stall_cnt, 32'd3);
    check("perf.flush", perf_flush_cnt, 32'd2);
    rst = 1'b0;
    #1;
    check("perf.rst.stall", perf_stall_cnt, 32'd0);
    check("perf.rst.flush", perf_flush_cnt, 32'd0);
    rst = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
